// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment calculator: mode encodings and the
// active-low hex-to-segment table used by the scan logic.
package sseg_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_DIFF = 2'd1,
    MODE_PROD = 2'd2,
    MODE_RAW  = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so HEX_SEG[n] decodes nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a one-cycle
// press pulse on each accepted released-to-pressed (1->0) transition.
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pb_raw};
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; one agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/sseg_calc_scan.sv
// IO-board calculator: DIP operands, button-stepped op, hex result scanned on a
// multiplexed seven-segment display. Option: SSEG_LEADING_ZERO_BLANK_EN.
module sseg_calc_scan
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic                  M_CLOCK,
  input  logic                  M_RESET_N,
  input  logic [3:0]            IO_PB,
  input  logic [7:0]            IO_DSW,
  output logic [NUM_DIGITS-1:0] IO_SSEGD,
  output logic [7:0]            IO_SSEG,
  output logic                  IO_SSEG_COL,
  output logic [7:0]            IO_LED
);

  localparam int unsigned DW   = 4 * NUM_DIGITS;
  localparam int unsigned DIGW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW   = $clog2(SCAN_DIV);
  localparam logic [DIGW-1:0] LAST_DIGIT = DIGW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
    if (!M_RESET_N) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic mode_level, mode_press;
  logic hold_level, hold_press;

  pb_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_pb_mode (
    .clk    (M_CLOCK),
    .rst_n  (rst_n),
    .pb_raw (IO_PB[0]),
    .level  (mode_level),
    .press  (mode_press)
  );

  pb_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_pb_hold (
    .clk    (M_CLOCK),
    .rst_n  (rst_n),
    .pb_raw (IO_PB[1]),
    .level  (hold_level),
    .press  (hold_press)
  );

  logic unused_pins;
  assign unused_pins = ^{IO_PB[3:2], mode_level, hold_level};

  mode_e mode_q, mode_d;
  logic  hold_q;

  always_ff @(posedge M_CLOCK or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_SUM;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      unique case (mode_q)
        MODE_SUM:  mode_d = MODE_DIFF;
        MODE_DIFF: mode_d = MODE_PROD;
        MODE_PROD: mode_d = MODE_RAW;
        MODE_RAW:  mode_d = MODE_SUM;
        default:   mode_d = MODE_SUM;
      endcase
    end
  end

  logic        ovf_q;
  logic [1:0]  mode_bits;

  always_comb begin
    mode_bits = mode_q;
    IO_LED    = {4'b0000, ovf_q, hold_q, mode_bits};
  end

  always_ff @(posedge M_CLOCK or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_q ^ hold_press;
  end

  logic [3:0]    op_a, op_b;
  logic [7:0]    res;
  logic          res_neg;
  logic [39:0]   res_ext;
  logic [DW-1:0] disp_d, disp_q;
  logic          ovf_d, neg_q;

  assign op_a = IO_DSW[7:4];
  assign op_b = IO_DSW[3:0];

  always_comb begin
    res     = 8'h00;
    res_neg = 1'b0;
    unique case (mode_q)
      MODE_SUM:  res = {3'b000, {1'b0, op_a} + {1'b0, op_b}};
      MODE_DIFF: begin
        res_neg = (op_a < op_b);
        res     = res_neg ? {4'h0, op_b - op_a} : {4'h0, op_a - op_b};
      end
      MODE_PROD: res = {4'h0, op_a} * {4'h0, op_b};
      MODE_RAW:  res = IO_DSW;
      default:   res = 8'h00;
    endcase
  end

  // Anything above the displayable width is dropped and flagged.
  assign res_ext = {32'h0, res};
  assign disp_d  = res_ext[DW-1:0];
  assign ovf_d   = |(res_ext >> DW);

  always_ff @(posedge M_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (!hold_q) begin
      disp_q <= disp_d;
      neg_q  <= res_neg;
      ovf_q  <= ovf_d;
    end
  end

  logic [PW-1:0]   presc_q, presc_d;
  logic [DIGW-1:0] digit_q, digit_d;

  always_ff @(posedge M_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      digit_d = (digit_q == LAST_DIGIT) ? '0 : digit_q + DIGW'(1);
    end
  end

  logic [NUM_DIGITS-1:0] blank_mask;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // A digit blanks when it and every digit above it is zero; digit 0 never blanks.
  always_comb begin : p_blank
    logic upper_zero;
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero & (disp_q[4*i +: 4] == 4'h0);
      blank_mask[i] = upper_zero & (i != 0);
    end
  end
`else
  assign blank_mask = '0;
`endif

  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] ssegd_d, ssegd_q;
  logic [7:0]            sseg_d, sseg_q;

  assign cur_nib = disp_q[{digit_q, 2'b00} +: 4];

  // Last prescaler count of each digit is a blank slot so the old pattern
  // never ghosts onto the next digit.
  always_comb begin
    ssegd_d = '1;
    sseg_d  = 8'hFF;
    if (presc_q != PRESC_LAST) begin
      ssegd_d     = ~(NUM_DIGITS'(1) << digit_q);
      sseg_d[6:0] = blank_mask[digit_q] ? SEG_OFF : hex_to_seg(cur_nib);
      sseg_d[7]   = ~(neg_q && (digit_q == LAST_DIGIT));
    end
  end

  always_ff @(posedge M_CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      ssegd_q <= '1;
      sseg_q  <= 8'hFF;
    end else begin
      ssegd_q <= ssegd_d;
      sseg_q  <= sseg_d;
    end
  end

  assign IO_SSEGD    = ssegd_q;
  assign IO_SSEG     = sseg_q;
  assign IO_SSEG_COL = 1'b1;

endmodule

// File: tb/tb_sseg_calc_scan.sv
// Scoreboard bench for sseg_calc_scan: a 4-digit and a 1-digit instance share
// the board inputs; a behavioural calculator model predicts each scanned frame.
module tb_sseg_calc_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pb = 4'hF;
  logic [7:0] dsw = 8'h35;

  logic [3:0] ssegd;
  logic [7:0] sseg;
  logic       col;
  logic [7:0] led;
  logic [0:0] ssegd1;
  logic [7:0] sseg1;
  logic       col1;
  logic [7:0] led1;

  always #5 clk = ~clk;

  sseg_calc_scan #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .DEBOUNCE_CYC (DC)
  ) dut (
    .M_CLOCK     (clk),
    .M_RESET_N   (rst_n),
    .IO_PB       (pb),
    .IO_DSW      (dsw),
    .IO_SSEGD    (ssegd),
    .IO_SSEG     (sseg),
    .IO_SSEG_COL (col),
    .IO_LED      (led)
  );

  sseg_calc_scan #(
    .NUM_DIGITS   (1),
    .SCAN_DIV     (SD),
    .DEBOUNCE_CYC (DC)
  ) dut1 (
    .M_CLOCK     (clk),
    .M_RESET_N   (rst_n),
    .IO_PB       (pb),
    .IO_DSW      (dsw),
    .IO_SSEGD    (ssegd1),
    .IO_SSEG     (sseg1),
    .IO_SSEG_COL (col1),
    .IO_LED      (led1)
  );

  typedef struct packed {
    logic [3:0][7:0] seg;
    logic [7:0]      led;
  } frame_t;

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] led;
  } frame1_t;

  frame_t  exp_q[$];
  frame1_t exp1_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Standard active-high a..g patterns for 0..F; the display is active-low.
  localparam logic [6:0] HEX_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int         mode_m = 0;
  bit         hold_m = 1'b0;
  int         res_m  = 0;
  bit         neg_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_eval();
    int a, b;
    a = int'(dsw[7:4]);
    b = int'(dsw[3:0]);
    if (!hold_m) begin
      neg_m = 1'b0;
      case (mode_m)
        0: res_m = a + b;
        1: begin
          neg_m = (a < b);
          res_m = neg_m ? b - a : a - b;
        end
        2: res_m = a * b;
        default: res_m = int'(dsw);
      endcase
    end
  endfunction

  function automatic frame_t make_frame();
    frame_t     f;
    int         nib;
    logic [6:0] s;
    logic [1:0] mb;
    for (int d = 0; d < ND; d++) begin
      nib = (res_m >> (4 * d)) & 15;
      s   = ~HEX_ON[nib];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (d > 0 && (res_m >> (4 * d)) == 0) s = 7'h7F;
`endif
      f.seg[d] = {~(neg_m && d == ND - 1), s};
    end
    mb    = mode_m[1:0];
    f.led = {4'b0000, 1'b0, hold_m, mb};
    return f;
  endfunction

  function automatic frame1_t make_frame1();
    frame1_t    f;
    logic [1:0] mb;
    mb    = mode_m[1:0];
    f.seg = {~neg_m, ~HEX_ON[res_m & 15]};
    f.led = {4'b0000, ((res_m >> 4) != 0), hold_m, mb};
    return f;
  endfunction

  // 4-digit monitor: sync to the next full frame, compare every digit.
  initial begin : mon4
    frame_t     mf;
    int         t;
    logic [3:0] en;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        mf = exp_q[0];
        t  = 0;
        while (ssegd !== 4'hF && t < 64) begin @(negedge clk); t++; end
        t = 0;
        while (ssegd !== 4'hE && t < 64) begin @(negedge clk); t++; end
        for (int d = 0; d < ND; d++) begin
          en = ~(4'b0001 << d);
          t  = 0;
          while (ssegd !== en && t < 64) begin @(negedge clk); t++; end
          check($sformatf("digit%0d_enable", d), ssegd, en);
          check($sformatf("digit%0d_segments", d), sseg, mf.seg[d]);
          if (d == 0) check("led", led, mf.led);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin : mon1
    frame1_t mf;
    int      t;
    forever begin
      @(negedge clk);
      if (exp1_q.size() != 0) begin
        mf = exp1_q[0];
        t  = 0;
        while (ssegd1 !== 1'b0 && t < 64) begin @(negedge clk); t++; end
        check("nd1_enable", ssegd1, 1'b0);
        check("nd1_segments", sseg1, mf.seg);
        check("nd1_led", led1, mf.led);
        if (exp1_q.size() != 0) void'(exp1_q.pop_front());
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      check("drain_timeout", exp_q.size() + exp1_q.size(), 0);
      exp_q.delete();
      exp1_q.delete();
    end
  endtask

  task automatic press(input logic [1:0] mask, input int len);
    @(posedge clk);
    #1;
    pb[1:0] = ~mask;
    repeat (len) @(posedge clk);
    #1;
    pb[1:0] = 2'b11;
    repeat (DC + 8) @(posedge clk);
  endtask

  task automatic step(input logic [1:0] mask, input int len, input logic [7:0] new_dsw);
    if (mask != 2'b00) begin
      press(mask, len);
      if (len >= DC + 2) begin
        if (mask[0]) mode_m = (mode_m + 1) % 4;
        if (mask[1]) hold_m = ~hold_m;
      end
      model_eval();
    end
    @(posedge clk);
    #1;
    dsw = new_dsw;
    repeat (3) @(posedge clk);
    model_eval();
    exp_q.push_back(make_frame());
    exp1_q.push_back(make_frame1());
    drain();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int         t;
    int         pos;
    logic [3:0] exp_en;
    logic [1:0] m;

    repeat (3) @(negedge clk);
    check("reset_ssegd", ssegd, 4'hF);
    check("reset_sseg", sseg, 8'hFF);
    check("reset_led", led, 8'h00);
    check("reset_col", col, 1'b1);
    check("reset_nd1_ssegd", ssegd1, 1'b1);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    t = 0;
    while (ssegd === 4'hF && t < 20) begin @(negedge clk); t++; end
    for (int k = 0; k < 20; k++) begin
      pos    = k % 16;
      exp_en = (pos % 4 < 3) ? ~(4'b0001 << (pos / 4)) : 4'hF;
      check($sformatf("scan_order_%0d", k), ssegd, exp_en);
      @(negedge clk);
    end

    mode_m = 0;
    hold_m = 1'b0;
    model_eval();

    step(2'b00, 0,  8'h35);  // SUM 8
    step(2'b01, 5,  8'h35);  // glitch too short
    step(2'b01, 12, 8'h3A);  // DIFF 0007, neg
    step(2'b01, 12, 8'hFF);  // PROD 00E1
    step(2'b01, 12, 8'hFF);  // RAW 00FF
    step(2'b01, 12, 8'hFF);  // SUM 001E
    step(2'b00, 0,  8'h11);
    step(2'b10, 12, 8'h11);  // hold on
    step(2'b00, 0,  8'h22);  // still 0002
    step(2'b10, 12, 8'h22);  // hold off -> 0004
    step(2'b01, 12, 8'h44);
    step(2'b01, 12, 8'h44);  // PROD 0x10: 1-digit overflow
    step(2'b11, 12, 8'h9C);  // simultaneous presses

    for (int i = 0; i < 40; i++) begin
      m = ($urandom_range(0, 2) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      step(m, ($urandom_range(0, 3) == 0) ? 4 : 12, 8'($urandom));
    end

    // Reset in the middle of a scan.
    @(posedge clk);
    repeat ($urandom_range(1, 15)) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_ssegd", ssegd, 4'hF);
    check("midreset_sseg", sseg, 8'hFF);
    check("midreset_led", led, 8'h00);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mode_m = 0;
    hold_m = 1'b0;
    step(2'b00, 0, 8'h5C);
    step(2'b01, 12, 8'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
